// File: rtl/neuron_sample_scheduler_pkg.sv
// Shared defaults and FSM state encoding for the neuron sample scheduler.
package neuron_sample_scheduler_pkg;

    localparam int unsigned ADDR_W_DEF     = 6;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned MAX_EPOCHS_DEF = 64;
    localparam int unsigned EPOCH_W_DEF    = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_FETCH    = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_PRESENT  = 3'd4,
        ST_DRAINED  = 3'd5
    } state_e;

endpackage

// File: rtl/neuron_sample_scheduler_if.sv
// Controller handshake and sample-memory bus of the neuron sample scheduler.
interface neuron_sample_scheduler_if #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned EPOCH_W = 7
);
    logic                      sess_init;
    logic [ADDR_W:0]           cfg_n;
    logic                      req;
    logic                      upd;
    logic                      epoch_rst;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic signed [DATA_W-1:0]  mem_x1;
    logic signed [DATA_W-1:0]  mem_x2;
    logic signed [DATA_W-1:0]  mem_t;
    logic signed [DATA_W-1:0]  x1;
    logic signed [DATA_W-1:0]  x2;
    logic signed [DATA_W-1:0]  t;
    logic                      data_ready;
    logic                      flag_eof;
    logic                      end_flag;
    logic [EPOCH_W-1:0]        epoch_cnt;
    logic                      busy;

    // scheduler side
    modport slave (
        input  sess_init, cfg_n, req, upd, epoch_rst, mem_x1, mem_x2, mem_t,
        output mem_rd, mem_addr, x1, x2, t, data_ready, flag_eof, end_flag, epoch_cnt, busy
    );

    // controller plus sample-memory side
    modport master (
        output sess_init, cfg_n, req, upd, epoch_rst, mem_x1, mem_x2, mem_t,
        input  mem_rd, mem_addr, x1, x2, t, data_ready, flag_eof, end_flag, epoch_cnt, busy
    );

endinterface

// File: rtl/neuron_sample_scheduler_epoch_tracker.sv
// Error and epoch bookkeeping; decides whether another epoch is needed.
module neuron_epoch_tracker #(
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned EPOCH_W    = 7,
    parameter int unsigned MAX_EPOCHS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sess_start,
    input  logic               epoch_adv,
    input  logic               upd,
    input  logic               active,
    input  logic               flag_eof_nxt,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               end_flag
);
    logic [CNT_W-1:0]   err_q, err_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               end_d;

    // next counts: session start beats epoch advance beats update
    always_comb begin
        err_d   = err_q;
        epoch_d = epoch_q;
        if (sess_start) begin
            err_d   = '0;
            epoch_d = '0;
        end else if (epoch_adv) begin
            err_d = '0;
            if (epoch_q < EPOCH_W'(MAX_EPOCHS)) begin
                epoch_d = epoch_q + EPOCH_W'(1);
            end
        end else if (upd && active && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
        end_d = flag_eof_nxt && (err_d != '0) && (epoch_d < EPOCH_W'(MAX_EPOCHS - 1));
    end

    // counters and end flag registered from their next values
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q    <= '0;
            epoch_q  <= '0;
            end_flag <= 1'b0;
        end else begin
            err_q    <= err_d;
            epoch_q  <= epoch_d;
            end_flag <= end_d;
        end
    end

    assign epoch_cnt = epoch_q;

endmodule

// File: rtl/neuron_sample_scheduler.sv
// Feeds (x1, x2, t) samples from memory to the neuron training controller.
module neuron_sample_scheduler
    import neuron_sample_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_EPOCHS = MAX_EPOCHS_DEF,
    parameter int unsigned EPOCH_W    = EPOCH_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    neuron_sample_scheduler_if.slave  bus
);
    localparam int unsigned       CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  N_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d, t_q, t_d;
    logic                     flag_eof_q, flag_eof_d;
    logic                     sess_start, epoch_adv;
    logic                     mem_rd_q, data_ready_q, busy_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [EPOCH_W-1:0]       epoch_cnt;
    logic                     end_flag;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // next state and datapath control; sess_init overrides everything
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        t_d        = t_q;
        flag_eof_d = flag_eof_q;
        sess_start = 1'b0;
        epoch_adv  = 1'b0;
        if (bus.sess_init) begin
            sess_start = 1'b1;
            n_d        = (bus.cfg_n > N_MAX) ? N_MAX : bus.cfg_n;
            idx_d      = '0;
            flag_eof_d = 1'b0;
            state_d    = ST_WAIT_REQ;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT_REQ: begin
                    if (bus.req) begin
                        if (idx_q < n_q) begin
                            state_d = ST_FETCH;
                        end else begin
                            x1_d       = '0;
                            x2_d       = '0;
                            t_d        = '0;
                            flag_eof_d = 1'b1;
                            state_d    = ST_PRESENT;
                        end
                    end
                end
                ST_FETCH: state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    x1_d    = bus.mem_x1;
                    x2_d    = bus.mem_x2;
                    t_d     = bus.mem_t;
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: state_d = flag_eof_q ? ST_DRAINED : ST_WAIT_REQ;
                ST_DRAINED: begin
                    if (bus.epoch_rst) begin
                        idx_d      = '0;
                        flag_eof_d = 1'b0;
                        epoch_adv  = 1'b1;
                        state_d    = ST_WAIT_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // sample index, session length and presented sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q      <= '0;
            n_q        <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            t_q        <= '0;
            flag_eof_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            n_q        <= n_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            t_q        <= t_d;
            flag_eof_q <= flag_eof_d;
        end
    end

    // strobes registered from the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mem_rd_q     <= (state_d == ST_FETCH);
            if (state_d == ST_FETCH) mem_addr_q <= idx_d[ADDR_W-1:0];
            data_ready_q <= (state_d == ST_PRESENT);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    neuron_epoch_tracker #(
        .CNT_W      (CNT_W),
        .EPOCH_W    (EPOCH_W),
        .MAX_EPOCHS (MAX_EPOCHS)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .sess_start   (sess_start),
        .epoch_adv    (epoch_adv),
        .upd          (bus.upd),
        .active       (state_q != ST_IDLE),
        .flag_eof_nxt (flag_eof_d),
        .epoch_cnt    (epoch_cnt),
        .end_flag     (end_flag)
    );

    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.x1         = x1_q;
    assign bus.x2         = x2_q;
    assign bus.t          = t_q;
    assign bus.data_ready = data_ready_q;
    assign bus.flag_eof   = flag_eof_q;
    assign bus.end_flag   = end_flag;
    assign bus.epoch_cnt  = epoch_cnt;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_neuron_sample_scheduler.sv
// Self-checking bench: transaction-level model of the scheduler plus directed literals.
module tb_neuron_sample_scheduler;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned EW = 7;
    localparam int unsigned ME = 3;
    localparam int NSLOTS  = 64;
    localparam int ERR_MAX = 127;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_sample_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .EPOCH_W(EW)) bus ();

    neuron_sample_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_EPOCHS(ME), .EPOCH_W(EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // sample memory contents and its 1-cycle read port
    logic signed [DW-1:0] mx1 [NSLOTS];
    logic signed [DW-1:0] mx2 [NSLOTS];
    logic signed [DW-1:0] mt  [NSLOTS];

    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_x1 <= mx1[bus.mem_addr];
            bus.mem_x2 <= mx2[bus.mem_addr];
            bus.mem_t  <= mt[bus.mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // model state
    int cyc = 0;
    int ready_at = -1;
    int fetch_at = -1;
    int exp_addr = 0;
    int m_n = 0, m_idx = 0, m_err = 0, m_epoch = 0;
    bit m_eof = 1'b0, m_active = 1'b0, req_fresh = 1'b0;
    logic signed [DW-1:0] m_x1 = '0, m_x2 = '0, m_t = '0;
    logic signed [DW-1:0] p1 = '0, p2 = '0, pt = '0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // advance the model over one clock edge using the inputs the DUT just sampled
    task automatic model_edge();
        cyc++;
        if (!rst) begin
            m_active = 1'b0; m_n = 0; m_idx = 0; m_err = 0; m_epoch = 0; m_eof = 1'b0;
            ready_at = -1; fetch_at = -1; req_fresh = 1'b0;
            m_x1 = '0; m_x2 = '0; m_t = '0;
        end else if (bus.sess_init) begin
            m_active = 1'b1;
            m_n = (int'(bus.cfg_n) > NSLOTS) ? NSLOTS : int'(bus.cfg_n);
            m_idx = 0; m_err = 0; m_epoch = 0; m_eof = 1'b0;
            ready_at = -1; req_fresh = 1'b0;
        end else if (m_active) begin
            if (bus.epoch_rst && m_eof && (cyc - 1) > ready_at) begin
                m_idx = 0; m_err = 0; m_eof = 1'b0;
                if (m_epoch < int'(ME)) m_epoch++;
            end else begin
                if (bus.upd && m_err < ERR_MAX) m_err++;
                if (req_fresh) begin
                    req_fresh = 1'b0;
                    if (m_idx < m_n) begin
                        fetch_at = cyc;
                        ready_at = cyc + 2;
                        exp_addr = m_idx;
                        p1 = mx1[m_idx]; p2 = mx2[m_idx]; pt = mt[m_idx];
                        m_idx++;
                    end else begin
                        ready_at = cyc;
                        m_eof = 1'b1;
                        p1 = '0; p2 = '0; pt = '0;
                    end
                end
            end
            if (cyc == ready_at) begin
                m_x1 = p1; m_x2 = p2; m_t = pt;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("cmp_busy", bus.busy, m_active);
            chk("cmp_data_ready", bus.data_ready, (cyc == ready_at));
            chk("cmp_mem_rd", bus.mem_rd, (cyc == fetch_at));
            if (cyc == fetch_at) chk("cmp_mem_addr", bus.mem_addr, exp_addr);
            chk("cmp_x1", bus.x1, m_x1);
            chk("cmp_x2", bus.x2, m_x2);
            chk("cmp_t", bus.t, m_t);
            chk("cmp_flag_eof", bus.flag_eof, m_eof);
            chk("cmp_end_flag", bus.end_flag, (m_eof && m_err != 0 && m_epoch < int'(ME) - 1));
            chk("cmp_epoch_cnt", bus.epoch_cnt, m_epoch);
        end
    end

    task automatic sess(input int n);
        bus.sess_init = 1'b1;
        bus.cfg_n = 7'(n);
        tick();
        bus.sess_init = 1'b0;
    endtask

    task automatic gap(input int n, input bit rnd, input bit erst);
        for (int k = 0; k < n; k++) begin
            bus.upd = rnd && ($urandom_range(0, 3) == 0);
            bus.epoch_rst = erst && ($urandom_range(0, 4) == 0);
            tick();
            bus.upd = 1'b0;
            bus.epoch_rst = 1'b0;
        end
    endtask

    // one request from WAIT_REQ; returns observed data_ready latency (-1 if none)
    task automatic do_req(input bit rnd, output int lat);
        int t0;
        lat = -1;
        t0 = cyc;
        bus.req = 1'b1;
        req_fresh = 1'b1;
        bus.upd = rnd && ($urandom_range(0, 3) == 0);
        tick();
        if (bus.data_ready && lat < 0) lat = cyc - t0;
        for (int k = 0; k < 4 && cyc < ready_at; k++) begin
            bus.upd = rnd && ($urandom_range(0, 3) == 0);
            tick();
            if (bus.data_ready && lat < 0) lat = cyc - t0;
        end
        bus.req = 1'b0;
        bus.upd = 1'b0;
        tick();
    endtask

    task automatic run_epoch(input bit rnd);
        int lat, exp;
        for (int g = 0; g < 200 && !m_eof; g++) begin
            exp = (m_idx < m_n) ? 3 : 1;
            do_req(rnd, lat);
            chk("req_latency", lat, exp);
            if (rnd) gap($urandom_range(0, 2), 1'b1, !m_eof);
        end
    endtask

    task automatic next_epoch(input bit rnd, input bit upd_too);
        bus.req = rnd;
        gap(rnd ? $urandom_range(1, 3) : 1, rnd, 1'b0);
        bus.req = 1'b0;
        bus.epoch_rst = 1'b1;
        bus.upd = upd_too;
        tick();
        bus.epoch_rst = 1'b0;
        bus.upd = 1'b0;
    endtask

    task automatic pulse_upd();
        bus.upd = 1'b1;
        tick();
        bus.upd = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int lat;
        logic signed [DW-1:0] ix1 [3] = '{8'sd1, -8'sd1, 8'sd4};
        logic signed [DW-1:0] ix2 [3] = '{8'sd2, 8'sd3, -8'sd2};
        logic signed [DW-1:0] it  [3] = '{8'sd1, -8'sd1, 8'sd1};
        for (int i = 0; i < NSLOTS; i++) begin
            mx1[i] = DW'($urandom); mx2[i] = DW'($urandom); mt[i] = DW'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            mx1[i] = ix1[i]; mx2[i] = ix2[i]; mt[i] = it[i];
        end
        rst = 1'b0;
        bus.sess_init = 1'b0; bus.cfg_n = '0; bus.req = 1'b0; bus.upd = 1'b0; bus.epoch_rst = 1'b0;
        bus.mem_x1 = '0; bus.mem_x2 = '0; bus.mem_t = '0;
        tick();
        checking = 1'b1;
        tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_epoch_cnt", bus.epoch_cnt, 0);
        chk("reset_x1", bus.x1, 0);
        rst = 1'b1;
        tick();

        // three samples then EOF, no updates
        sess(3);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, lat);
            chk("t1_latency", lat, 3);
            chk("t1_x1", bus.x1, ix1[i]);
            chk("t1_x2", bus.x2, ix2[i]);
            chk("t1_t", bus.t, it[i]);
            chk("t1_flag_eof", bus.flag_eof, 0);
        end
        do_req(1'b0, lat);
        chk("t1_eof_latency", lat, 1);
        chk("t1_eof_flag", bus.flag_eof, 1);
        chk("t1_eof_x1", bus.x1, 0);
        chk("t3_end_flag", bus.end_flag, 0);
        chk("t3_epoch_cnt", bus.epoch_cnt, 0);

        // second epoch replays from address 0, with one update
        next_epoch(1'b0, 1'b0);
        chk("t2_epoch_cnt", bus.epoch_cnt, 1);
        do_req(1'b0, lat);
        chk("t2_replay_x1", bus.x1, 1);
        chk("t2_replay_t", bus.t, 1);
        pulse_upd();
        run_epoch(1'b0);
        chk("t2_end_flag", bus.end_flag, 1);

        // epoch limit, update/epoch_rst collision, saturation
        sess(1);
        pulse_upd();
        run_epoch(1'b0);
        chk("t4_e0_end_flag", bus.end_flag, 1);
        next_epoch(1'b0, 1'b1);
        run_epoch(1'b0);
        chk("t4_upd_cleared_end_flag", bus.end_flag, 0);
        next_epoch(1'b0, 1'b0);
        pulse_upd();
        run_epoch(1'b0);
        chk("t4_limit_epoch_cnt", bus.epoch_cnt, 2);
        chk("t4_limit_end_flag", bus.end_flag, 0);
        next_epoch(1'b0, 1'b0);
        run_epoch(1'b0);
        next_epoch(1'b0, 1'b0);
        chk("t4_sat_epoch_cnt", bus.epoch_cnt, 3);

        // empty sample set
        sess(0);
        do_req(1'b0, lat);
        chk("t5_latency", lat, 1);
        chk("t5_flag_eof", bus.flag_eof, 1);

        // reset during CAPTURE
        sess(3);
        do_req(1'b0, lat);
        bus.req = 1'b1; req_fresh = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_x1", bus.x1, 0);
        chk("t6_rst_data_ready", bus.data_ready, 0);
        pulse_upd();

        // session restart during FETCH
        sess(2);
        bus.req = 1'b1; req_fresh = 1'b1;
        tick();
        chk("t6_fetch_mem_rd", bus.mem_rd, 1);
        bus.req = 1'b0;
        sess(5);
        tick();
        tick();
        chk("t6_abort_data_ready", bus.data_ready, 0);
        do_req(1'b0, lat);
        chk("t6_restart_x1", bus.x1, 1);
        run_epoch(1'b0);

        // oversized sample count
        sess(100);
        run_epoch(1'b1);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            int ne;
            sess($urandom_range(0, 70));
            ne = $urandom_range(1, 4);
            for (int e = 0; e < ne; e++) begin
                run_epoch(1'b1);
                if (e < ne - 1) next_epoch(1'b1, ($urandom_range(0, 1) == 1));
            end
            gap(2, 1'b1, 1'b0);
        end

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_sample_scheduler.md
Name: neuron_sample_scheduler

Overview:
- Sequences training samples into the two-input neuron datapath on behalf of the neuron training controller.
- Answers the controller's request/ready handshake by fetching (x1, x2, t) triples from a sample memory that has a 1-cycle read latency.
- Signals end-of-epoch, counts epochs and weight-update errors, and drives the end flag that tells the controller whether to run another epoch.

Parameters:
ADDR_W, 6, sample-memory address width; at most 2^ADDR_W samples.
DATA_W, 8, width of signed x1, x2 and t.
MAX_EPOCHS, 64, epoch limit; no further epoch is requested once the limit is reached.
EPOCH_W, 7, epoch counter width; must satisfy 2^EPOCH_W > MAX_EPOCHS.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous active-low reset (0 = reset).
sess_init  in  1  pulse; start a training session (driven from the controller's init state).
cfg_n  in  ADDR_W+1  sample count; sampled on sess_init.
req  in  1  level request for the next sample (controller requestFlag).
upd  in  1  pulse; a weight update occurred (controller changeWeight).
epoch_rst  in  1  pulse; begin the next epoch (controller counter reset).
mem_rd  out  1  sample-memory read strobe.
mem_addr  out  ADDR_W  sample-memory address.
mem_x1, mem_x2, mem_t  in  DATA_W each  memory read data; valid 1 cycle after mem_rd.
x1, x2, t  out  DATA_W each  presented sample; held until the next capture.
data_ready  out  1  one-cycle pulse; x1/x2/t and flag_eof are valid.
flag_eof  out  1  level; all cfg_n samples of the current epoch are consumed.
end_flag  out  1  level; another epoch is required.
epoch_cnt  out  EPOCH_W  number of completed epochs.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at an edge) sets the FSM to IDLE and clears idx, err_cnt, epoch_cnt, x1/x2/t, n_reg and all outputs to 0.
- FSM states: IDLE, WAIT_REQ, FETCH, CAPTURE, PRESENT, DRAINED.
- IDLE: on sess_init, load n_reg=cfg_n and clear idx, err_cnt and epoch_cnt; go to WAIT_REQ.
- WAIT_REQ:
  - req=1 and idx<n_reg: go to FETCH.
  - req=1 and idx==n_reg: clear x1/x2/t to 0, set flag_eof=1, go to PRESENT.
- FETCH: mem_rd=1 and mem_addr=idx[ADDR_W-1:0] for exactly one cycle; go to CAPTURE.
- CAPTURE: register mem_x1, mem_x2 and mem_t into x1/x2/t; increment idx; go to PRESENT.
- PRESENT: data_ready=1 for one cycle.
  - If flag_eof=1, go to DRAINED; otherwise go to WAIT_REQ.
  - Latency from req sampled high to data_ready is 3 cycles; an EOF answer takes 1 cycle.
- DRAINED:
  - req is ignored.
  - On epoch_rst: clear idx, err_cnt and flag_eof; set epoch_cnt+=1 (saturating at MAX_EPOCHS); go to WAIT_REQ.
  - On sess_init: behave as in IDLE.
- upd increments err_cnt in any non-IDLE state. err_cnt is ADDR_W+1 bits and saturates.
- end_flag = flag_eof && (err_cnt!=0) && (epoch_cnt < MAX_EPOCHS-1). It is valid from the PRESENT cycle of the EOF answer onward, so the controller's checkEndFlag state sees a stable value.
- Priority per cycle: rst > sess_init > epoch_rst > req. sess_init in any state restarts the session and aborts any in-flight fetch; no data_ready is issued for the aborted fetch.
- epoch_rst outside DRAINED is ignored.
- cfg_n=0: the first req gets an immediate EOF answer.
- cfg_n > 2^ADDR_W is clamped to 2^ADDR_W at load.
- upd and epoch_rst in the same cycle: epoch_rst wins and err_cnt is cleared (that update belongs to the finished epoch).
- busy=0 only in IDLE.

Decomposition:
- Shared package: state encoding enum (3 bits), DATA_W/ADDR_W defaults, MAX_EPOCHS default.
- One natural sub-module: neuron_epoch_tracker, holding err_cnt, epoch_cnt and the end_flag logic.
- The FSM, idx counter and sample registers stay in the top level.

Test Plan:
1. cfg_n=3, memory {(1,2,1),(-1,3,-1),(4,-2,1)}, req held each time -> three data_ready pulses, each 3 cycles after req, with matching x1/x2/t and flag_eof=0; the fourth req -> data_ready 1 cycle later with flag_eof=1 and x=0.
2. Same memory with one upd pulse during the epoch -> end_flag=1 at EOF; after epoch_rst, epoch_cnt=1 and idx replays from address 0.
3. No upd during the epoch -> end_flag=0 at EOF while epoch_cnt=0.
4. MAX_EPOCHS=2 with upd in every epoch -> end_flag=1 after epoch 0 and end_flag=0 after epoch 1.
5. cfg_n=0 -> the first req gives data_ready plus flag_eof in 1 cycle and mem_rd never asserts.
6. rst=0 during CAPTURE -> all outputs 0 on the next edge; sess_init during FETCH -> no data_ready, idx=0, n_reg reloaded.
